// File: rtl/config_reg_pkg.sv
// Shared types and sizing helpers for the configuration shift engines.
package config_reg_pkg;

   // Transfer sequencing states
   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOW,
      HIGH,
      LOAD,
      DONE
   } state_t;

   // Number of stream words needed to carry one transfer
   function automatic int unsigned cfg_nwords(input int unsigned reg_width,
                                              input int unsigned data_width);
      return (reg_width + data_width - 1) / data_width;
   endfunction

   // Number of meaningful bits in the final word of a transfer
   function automatic int unsigned cfg_last_bits(input int unsigned reg_width,
                                                 input int unsigned data_width);
      return reg_width - (cfg_nwords(reg_width, data_width) - 1) * data_width;
   endfunction

   // Counter width for a modulus of n, never narrower than one bit
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/config_clk_phase.sv
// Half-period phase counter for the divided configuration clock.
// Counts HALF system cycles per phase and strobes phase_end on the last one;
// clear holds it at the start of a phase. Shared with the read-only engine.
module config_clk_phase
   import config_reg_pkg::*;
#(
   parameter int unsigned HALF = 50
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic phase_end
);

   localparam int unsigned CW = cnt_width(2 * HALF);
   localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

   logic [CW-1:0] cnt;

   // Last cycle of the current half period
   always_comb begin
      phase_end = !clear && (cnt == CNT_LAST);
   end

   // Phase counter: wraps at the end of every half period
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear || phase_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/config_shift_engine.sv
// Serial configuration engine: takes words from the tx stream, shifts them
// LSB-first into the chip on a divided ConfigClk, captures ConfigOut into
// packed readback words and finishes each transfer with a ConfigLoad pulse.
module config_shift_engine
   import config_reg_pkg::*;
#(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned CONFIG_REG_WIDTH   = 5164,
   parameter int unsigned CLK_DIVIDER        = 100
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESET,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic [C_S_AXI_DATA_WIDTH-1:0] rb_data,
   output logic                          rb_valid,
   output logic                          ConfigClk,
   output logic                          ConfigIn,
   output logic                          ConfigLoad,
   input  logic                          ConfigOut
);

   localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
   localparam int unsigned HALF  = CLK_DIVIDER / 2;
   localparam int unsigned IDX_W = cnt_width(DW);
   localparam int unsigned BIT_W = cnt_width(CONFIG_REG_WIDTH + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DW - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CONFIG_REG_WIDTH - 1);

   state_t           state;
   logic [DW-1:0]    word_sr;
   logic [DW-1:0]    word_next;
   logic [DW-1:0]    rb_acc;
   logic [DW-1:0]    rb_sample;
   logic [IDX_W-1:0] bit_idx;
   logic [BIT_W-1:0] bit_cnt;
   logic             load_second;
   logic             phase_clear;
   logic             phase_end;
   logic             last_of_word;
   logic             last_of_xfer;

   config_clk_phase #(
      .HALF(HALF)
   ) u_phase (
      .clk      (S_AXI_ACLK),
      .rst      (S_AXI_ARESET),
      .clear    (phase_clear),
      .phase_end(phase_end)
   );

   // Phase timing only runs while the serial clock is being generated
   always_comb begin
      phase_clear  = (state == IDLE) || (state == FETCH) || (state == DONE);
      last_of_word = (bit_idx == IDX_LAST);
      last_of_xfer = (bit_cnt == BIT_LAST);
      word_next    = word_sr >> 1;
   end

   // Readback word with the bit being sampled this cycle merged in
   always_comb begin
      rb_sample          = rb_acc;
      rb_sample[bit_idx] = ConfigOut;
   end

   // Transfer sequencer; every output is a register updated on transitions
   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         state       <= IDLE;
         word_sr     <= '0;
         rb_acc      <= '0;
         bit_idx     <= '0;
         bit_cnt     <= '0;
         load_second <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         tx_ready    <= 1'b0;
         rb_data     <= '0;
         rb_valid    <= 1'b0;
         ConfigClk   <= 1'b0;
         ConfigIn    <= 1'b0;
         ConfigLoad  <= 1'b0;
      end else begin
         done     <= 1'b0;
         rb_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= FETCH;
                  busy     <= 1'b1;
                  tx_ready <= 1'b1;
                  bit_cnt  <= '0;
               end
            end
            FETCH: begin
               if (tx_valid) begin
                  state    <= LOW;
                  tx_ready <= 1'b0;
                  word_sr  <= tx_data;
                  rb_acc   <= '0;
                  bit_idx  <= '0;
                  ConfigIn <= tx_data[0];
               end
            end
            LOW: begin
               if (phase_end) begin
                  state     <= HIGH;
                  ConfigClk <= 1'b1;
               end
            end
            HIGH: begin
               if (phase_end) begin
                  ConfigClk <= 1'b0;
                  rb_acc    <= rb_sample;
                  bit_cnt   <= bit_cnt + BIT_W'(1);
                  if (last_of_word || last_of_xfer) begin
                     rb_data  <= rb_sample;
                     rb_valid <= 1'b1;
                  end
                  if (last_of_xfer) begin
                     state      <= LOAD;
                     ConfigIn   <= 1'b0;
                     ConfigLoad <= 1'b1;
                  end else if (last_of_word) begin
                     state    <= FETCH;
                     tx_ready <= 1'b1;
                  end else begin
                     state    <= LOW;
                     word_sr  <= word_next;
                     bit_idx  <= bit_idx + IDX_W'(1);
                     ConfigIn <= word_next[0];
                  end
               end
            end
            LOAD: begin
               // LOAD spans two phase periods, i.e. one full ConfigClk period
               if (phase_end) begin
                  if (load_second) begin
                     state       <= DONE;
                     load_second <= 1'b0;
                     ConfigLoad  <= 1'b0;
                     busy        <= 1'b0;
                     done        <= 1'b1;
                  end else begin
                     load_second <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_config_shift_engine.sv
// Scoreboard bench for config_shift_engine: a 40-bit chip model on the main
// instance and a full-width instance with ConfigOut tied high.
module tb_config_shift_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] tx_data = '0;
   logic        tx_valid = 1'b0;
   logic        busy, done, tx_ready, rb_valid;
   logic [31:0] rb_data;
   logic        ConfigClk, ConfigIn, ConfigLoad;
   logic        chip_out = 1'b0;

   logic        start2 = 1'b0;
   logic        tx_valid2 = 1'b1;
   logic [31:0] tx_data2 = 32'hC0FFEE00;
   logic        busy2, done2, tx_ready2, rb_valid2;
   logic [31:0] rb_data2;
   logic        ConfigClk2, ConfigIn2, ConfigLoad2;
   logic        cfg_out2 = 1'b1;

   logic [39:0] chip = '0;
   logic [39:0] par_out = '0;
   logic [39:0] preload_val = '0;
   logic [39:0] stream = '0;
   logic        preload_req = 1'b0;
   logic        stat_clr = 1'b0;
   logic        cfg_clk_q = 1'b0;
   logic        cfg_clk2_q = 1'b0;
   logic        stall_bad = 1'b0;
   int          cyc = 0;
   int          edge_cnt = 0, load_cyc = 0, hs_cnt = 0, done_cnt = 0, stall_cyc = 0;
   int          edge2 = 0, hs2 = 0, rb2_cnt = 0, done2_cnt = 0;
   int          start_cyc = 0, start2_cyc = 0;
   int          checks = 0, errors = 0;

   logic [31:0] rb_q[$];
   int          done_q[$];
   logic [31:0] rb2_q[$];
   int          done2_q[$];

   config_shift_engine #(
      .C_S_AXI_DATA_WIDTH(32),
      .CONFIG_REG_WIDTH  (40),
      .CLK_DIVIDER       (4)
   ) dut (
      .S_AXI_ACLK  (clk),
      .S_AXI_ARESET(rst),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rb_data     (rb_data),
      .rb_valid    (rb_valid),
      .ConfigClk   (ConfigClk),
      .ConfigIn    (ConfigIn),
      .ConfigLoad  (ConfigLoad),
      .ConfigOut   (chip_out)
   );

   config_shift_engine #(
      .C_S_AXI_DATA_WIDTH(32),
      .CONFIG_REG_WIDTH  (5164),
      .CLK_DIVIDER       (4)
   ) dut2 (
      .S_AXI_ACLK  (clk),
      .S_AXI_ARESET(rst),
      .start       (start2),
      .busy        (busy2),
      .done        (done2),
      .tx_data     (tx_data2),
      .tx_valid    (tx_valid2),
      .tx_ready    (tx_ready2),
      .rb_data     (rb_data2),
      .rb_valid    (rb_valid2),
      .ConfigClk   (ConfigClk2),
      .ConfigIn    (ConfigIn2),
      .ConfigLoad  (ConfigLoad2),
      .ConfigOut   (cfg_out2)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Chip model and event counters, sampled on the system clock
   always @(posedge clk) begin
      cyc        <= cyc + 1;
      cfg_clk_q  <= ConfigClk;
      cfg_clk2_q <= ConfigClk2;
      if (preload_req) begin
         chip <= preload_val;
      end else if (ConfigClk && !cfg_clk_q) begin
         chip_out <= chip[0];
         chip     <= {ConfigIn, chip[39:1]};
      end
      if (stat_clr) begin
         edge_cnt <= 0; load_cyc <= 0; hs_cnt <= 0; done_cnt <= 0;
         stall_cyc <= 0; stall_bad <= 1'b0; stream <= '0;
         edge2 <= 0; hs2 <= 0; rb2_cnt <= 0; done2_cnt <= 0;
      end else begin
         if (ConfigClk && !cfg_clk_q) begin
            if (edge_cnt < 40) stream[edge_cnt] <= ConfigIn;
            edge_cnt <= edge_cnt + 1;
         end
         if (ConfigLoad) begin
            load_cyc <= load_cyc + 1;
            par_out  <= chip;
         end
         if (tx_valid && tx_ready) hs_cnt <= hs_cnt + 1;
         if (tx_ready && !tx_valid) begin
            stall_cyc <= stall_cyc + 1;
            if (ConfigClk) stall_bad <= 1'b1;
         end
         if (done) done_cnt <= done_cnt + 1;
         if (ConfigClk2 && !cfg_clk2_q) edge2 <= edge2 + 1;
         if (tx_valid2 && tx_ready2) hs2 <= hs2 + 1;
         if (rb_valid2) rb2_cnt <= rb2_cnt + 1;
         if (done2) done2_cnt <= done2_cnt + 1;
      end
   end

   // Monitor: pops expected readback words and done spans as they appear
   always @(negedge clk) begin
      if (rb_valid) begin
         if (rb_q.size() == 0) check("rb_spurious", {63'd0, rb_valid}, 64'd0);
         else check("rb_data", rb_data, rb_q.pop_front());
      end
      if (done) begin
         if (done_q.size() == 0) check("done_spurious", {63'd0, done}, 64'd0);
         else check("done_span", cyc - start_cyc + 1, done_q.pop_front());
      end
      if (rb_valid2) begin
         if (rb2_q.size() == 0) check("rb2_spurious", {63'd0, rb_valid2}, 64'd0);
         else check("rb2_data", rb_data2, rb2_q.pop_front());
      end
      if (done2) begin
         if (done2_q.size() == 0) check("done2_spurious", {63'd0, done2}, 64'd0);
         else check("done2_span", cyc - start2_cyc + 1, done2_q.pop_front());
      end
   end

   task automatic run_transfer(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                               input logic [39:0] preload, input int stall, input int busy_start_at,
                               input int rst_at_edge, input logic [31:0] exp_rb0,
                               input logic [31:0] exp_rb1, input logic [39:0] exp_stream,
                               input int exp_edges, input int exp_span);
      int wait_cnt;
      bit stop;
      wait_cnt = 0;
      stop = 1'b0;
      @(posedge clk); #1;
      preload_val = preload; preload_req = 1'b1; stat_clr = 1'b1;
      @(posedge clk); #1;
      preload_req = 1'b0; stat_clr = 1'b0;
      if (rst_at_edge < 0) begin
         rb_q.push_back(exp_rb0);
         rb_q.push_back(exp_rb1);
         done_q.push_back(exp_span);
      end
      start = 1'b1; tx_data = w0; tx_valid = 1'b1; start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_busy_c1"}, busy, 1);
      check({tag, "_tx_ready_c1"}, tx_ready, 1);
      for (int n = 0; n < 600 && !stop; n++) begin
         if (hs_cnt == 0) begin
            tx_valid = 1'b1; tx_data = w0;
         end else if (hs_cnt == 1) begin
            tx_data = w1;
            if (tx_ready) begin
               tx_valid = (wait_cnt >= stall);
               wait_cnt++;
            end else begin
               tx_valid = (stall == 0);
            end
         end else begin
            tx_valid = 1'b0;
         end
         start = (n == busy_start_at);
         @(posedge clk); #1;
         if (rst_at_edge >= 0 && edge_cnt == rst_at_edge) begin
            check({tag, "_clk_high_at_reset"}, ConfigClk, 1);
            start = 1'b0; tx_valid = 1'b0; rst = 1'b1;
            #1;
            check({tag, "_outputs_in_reset"},
                  {busy, done, tx_ready, rb_valid, rb_data, ConfigClk, ConfigIn, ConfigLoad}, 64'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            stop = 1'b1;
         end else if (done_cnt != 0) begin
            stop = 1'b1;
         end
      end
      start = 1'b0; tx_valid = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check({tag, "_edges"}, edge_cnt, exp_edges);
      check({tag, "_stream"}, stream, exp_stream);
      if (rst_at_edge >= 0) begin
         check({tag, "_no_done"}, done_cnt, 0);
      end else begin
         check({tag, "_done_count"}, done_cnt, 1);
         check({tag, "_chip_contents"}, chip, exp_stream);
         check({tag, "_parallel_out"}, par_out, exp_stream);
         check({tag, "_load_cycles"}, load_cyc, 4);
         check({tag, "_stall_cycles"}, stall_cyc, stall);
         check({tag, "_clk_high_in_stall"}, stall_bad, 0);
         check({tag, "_tx_handshakes"}, hs_cnt, 2);
         check({tag, "_rb_pending"}, rb_q.size(), 0);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs",
            {busy, done, tx_ready, rb_valid, rb_data, ConfigClk, ConfigIn, ConfigLoad}, 64'd0);
      check("reset_outputs2",
            {busy2, done2, tx_ready2, rb_valid2, rb_data2, ConfigClk2, ConfigIn2, ConfigLoad2}, 64'd0);
      rst = 1'b0;

      // Basic transfer with readback of a preloaded chip
      run_transfer("basic", 32'hA5A5A5A5, 32'h000000FF, 40'h12_3456789A, 0, -1, -1,
                   32'h3456789A, 32'h00000012, 40'hFF_A5A5A5A5, 40, 168);
      // Second word delayed by 10 cycles; upper bits of the last word are ignored
      run_transfer("stall", 32'h13579BDF, 32'hFFFFFF3C, 40'hAB_CDEF0123, 10, -1, -1,
                   32'hCDEF0123, 32'h000000AB, 40'h3C_13579BDF, 40, 178);
      // Start pulsed mid-transfer must be ignored
      run_transfer("busy_start", 32'h0F0F0F0F, 32'h00000055, 40'h00_FFFF0000, 0, 60, -1,
                   32'hFFFF0000, 32'h00000000, 40'h55_0F0F0F0F, 40, 168);
      // Reset while bit 17 is high: 18 edges seen, nothing reported
      run_transfer("reset_mid", 32'hDEADBEEF, 32'h00000007, 40'h00_00000000, 0, -1, 18,
                   32'h0, 32'h0, 40'h00_0001BEEF, 18, 0);
      // Full transfer after the aborted one
      run_transfer("after_reset", 32'h01234567, 32'h00000089, 40'h5A_C3C3C3C3, 0, -1, -1,
                   32'hC3C3C3C3, 32'h0000005A, 40'h89_01234567, 40, 168);

      // Full-width transfer: 162 words, last word keeps only 12 bits
      @(posedge clk); #1;
      stat_clr = 1'b1;
      for (int i = 0; i < 161; i++) rb2_q.push_back(32'hFFFFFFFF);
      rb2_q.push_back(32'h00000FFF);
      done2_q.push_back(20824);
      @(posedge clk); #1;
      stat_clr = 1'b0;
      start2 = 1'b1; start2_cyc = cyc;
      @(posedge clk); #1;
      start2 = 1'b0;
      for (int n = 0; n < 25000 && done2_cnt == 0; n++) @(posedge clk);
      repeat (8) @(posedge clk);
      #1;
      check("wide_done_count", done2_cnt, 1);
      check("wide_tx_handshakes", hs2, 162);
      check("wide_rb_strobes", rb2_cnt, 162);
      check("wide_edges", edge2, 5164);
      check("wide_rb_pending", rb2_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/config_shift_engine.md
# config_shift_engine

Serial engine between the config-register AXI bank and the chip configuration pins. It pulls configuration words from a word stream and shifts them LSB-first into the chip shift register on a divided `ConfigClk`, capturing `ConfigOut` as it shifts. Captured bits are returned as packed readback words, and one `ConfigLoad` pulse is issued at the end of each transfer. The AXI bank feeds `tx_*`, sinks `rb_*`, and drives `start`.

## Interface
- `C_S_AXI_DATA_WIDTH`, 32: word width on `tx_data`/`rb_data`.
- `CONFIG_REG_WIDTH`, 5164: bits per transfer; ≥1.
- `CLK_DIVIDER`, 100: `S_AXI_ACLK` cycles per `ConfigClk` period; even, ≥4.

Ports:
- `S_AXI_ACLK` in 1: single clock.
- `S_AXI_ARESET` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle request to begin a transfer.
- `busy` out 1: high from the cycle after accepted `start` until `done`.
- `done` out 1: one-cycle pulse at end of transfer.
- `tx_data` in DATA_WIDTH: next configuration word.
- `tx_valid` in 1: `tx_data` valid.
- `tx_ready` out 1: engine accepts a word.
- `rb_data` out DATA_WIDTH: packed readback word.
- `rb_valid` out 1: one-cycle strobe; no backpressure.
- `ConfigClk` out 1: shift clock to chip.
- `ConfigIn` out 1: serial data to chip.
- `ConfigLoad` out 1: latch shift register into ParallelOut.
- `ConfigOut` in 1: serial data from chip.

## Operation
- Derived values:
  - NWORDS = ceil(CONFIG_REG_WIDTH/DATA_WIDTH).
  - LAST_BITS = CONFIG_REG_WIDTH − (NWORDS−1)·DATA_WIDTH.
  - HALF = CLK_DIVIDER/2.
- Bit order:
  - Word k bit i is transfer bit k·DATA_WIDTH+i, shifted LSB first.
  - Bits of the last word above LAST_BITS are ignored.
- States and transitions:
  - IDLE → FETCH on `start`. `start` while busy is ignored.
  - FETCH: `tx_ready`=1; on `tx_valid`&&`tx_ready`, load the word shift register → LOW.
  - LOW: `ConfigClk`=0, `ConfigIn`=current bit; HALF cycles → HIGH.
  - HIGH: `ConfigClk`=1 for HALF cycles.
    - On its last cycle, sample `ConfigOut` into the readback register at the current bit position.
    - Then: bit was last of transfer → LOAD; last of word → FETCH; otherwise advance bit → LOW.
  - LOAD: `ConfigClk`=0, `ConfigLoad`=1 for CLK_DIVIDER cycles → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- Readback:
  - `rb_valid` pulses once per word on the cycle after that word's final sample, with bits filled LSB-first.
  - The final word is zero-padded above LAST_BITS.
  - Exactly NWORDS strobes per transfer.
- Word stall: if `tx_valid` is low in FETCH, hold `ConfigClk`=0 indefinitely; no partial edges.
- Reset mid-transfer: all outputs go to 0 immediately, state → IDLE, counters cleared. No `done` and no further `rb_valid`.

## Timing
- Reset values: `busy`, `done`, `tx_ready`, `rb_valid`, `rb_data`, `ConfigClk`, `ConfigIn` and `ConfigLoad` are all 0.
- All outputs are registered; `ConfigClk`/`ConfigIn`/`ConfigLoad` are glitch-free.
- `ConfigIn` changes only on the cycle `ConfigClk` goes low, giving ≥HALF cycles of setup to the rising edge.
- Cycle numbering: `start` at cycle 0; FETCH (`busy`=1, `tx_ready`=1) at cycle 1.
- With `tx_valid` held high, the handshake is at cycle 1 and the first LOW is at cycle 2.
- Each word adds one FETCH cycle.
- Minimum transfer (`start` to `done`) = NWORDS + CONFIG_REG_WIDTH·CLK_DIVIDER + CLK_DIVIDER + 2 cycles.
- Phase counter width: clog2(HALF·2). Bit counter width: clog2(CONFIG_REG_WIDTH+1).

## Structure
- Package `config_reg_pkg`:
  - State enum (IDLE, FETCH, LOW, HIGH, LOAD, DONE).
  - Functions for NWORDS and LAST_BITS.
  - Counter-width helper.
- Sub-module `config_clk_phase`: HALF-period phase counter with `phase_end` strobe and clear. Reused by the read-only engine.

## Test plan
- CONFIG_REG_WIDTH=40, CLK_DIVIDER=4:
  - Stimulus: words 0xA5A5A5A5, 0x000000FF; `ConfigOut` looped from a 40-bit chip model.
  - Required: `ConfigIn` shows 40 bits LSB-first; exactly 40 rising edges; `ConfigLoad` high 4 cycles; `done` at cycle 2+2+160+4 = 168.
- Readback:
  - Stimulus: chip model preloaded with 0x12_3456789A.
  - Required: `rb_data` = 0x3456789A then 0x00000012; two `rb_valid` strobes.
- Word stall:
  - Stimulus: drop `tx_valid` 10 cycles before the second word.
  - Required: `ConfigClk` low throughout the stall; bitstream unchanged; `done` delayed by 10.
- Start while busy:
  - Stimulus: pulse `start` mid-transfer.
  - Required: ignored; exactly one `done`; 40 edges.
- Reset mid-transfer:
  - Stimulus: assert `S_AXI_ARESET` during HIGH of bit 17.
  - Required: all outputs 0 on the same edge; no `done`.
  - Then a new `start` runs a full correct transfer.
- Defaults 5164/100:
  - Required: 162 `tx` handshakes and 162 `rb` strobes; last readback has zeros above bit 11.
